mem_xfer_sequencer: RTL

- Hardware control sequencer for the execute phase of ld, ldi and st in the bus-based RISC datapath.
- Replaces hand-driven T0..T5 control strobes with an FSM that drives the datapath control inputs directly.
- Generalised over memory read latency and write pulse length.
- Adds a start/busy/done handshake and illegal-mode reporting.

---
 rtl/mem_xfer_sequencer.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_xfer_sequencer.sv
`timescale 1ns/1ps
// mem_xfer_sequencer
//   Execute-phase control sequencer for ld / ldi / st on the bus-based RISC
//   datapath. Drives the datapath control strobes directly from an FSM,
//   with a start/busy/done handshake and illegal-mode reporting.
//
// Parameters
//   RD_WAIT    cycles mem_read is held in the load read state (1..15)
//   WR_CYCLES  cycles mem_write is held in the store write state (1..15)
//
// Ports
//   clock                 rising-edge system clock
//   clear                 asynchronous active-low reset
//   start, mode[1:0]      request + operation (00 ld, 01 ldi, 10 st, 11 illegal)
//   busy, done, err       handshake / status
//   grb, baout, ryi       rb onto bus, load Y
//   csigno, alu_add, zi   sign-extended C onto bus, ALU add, load Z
//   zlo_out               Zlo onto bus
//   gra, rin, rout        ra select, register write, register read
//   mari, mdri, mdro      MAR load, MDR load, MDR drive
//   mem_read, mem_write   RAM read (also MDR mux select), RAM write
module mem_xfer_sequencer #(
  parameter int RD_WAIT   = 1,
  parameter int WR_CYCLES = 1
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       start,
  input  logic [1:0] mode,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       grb,
  output logic       baout,
  output logic       ryi,
  output logic       csigno,
  output logic       alu_add,
  output logic       zi,
  output logic       zlo_out,
  output logic       gra,
  output logic       rin,
  output logic       rout,
  output logic       mari,
  output logic       mdri,
  output logic       mdro,
  output logic       mem_read,
  output logic       mem_write
);

  typedef enum logic [2:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_DONE
  } state_t;

  typedef struct packed {
    logic busy, done, err;
    logic grb, baout, ryi;
    logic csigno, alu_add, zi;
    logic zlo_out, gra, rin, rout;
    logic mari, mdri, mdro;
    logic mem_read, mem_write;
  } ctl_t;

  localparam logic [1:0] MODE_LD  = 2'b00;
  localparam logic [1:0] MODE_LDI = 2'b01;
  localparam logic [1:0] MODE_ST  = 2'b10;
  localparam logic [1:0] MODE_ILL = 2'b11;

  localparam logic [3:0] RD_LAST = 4'(RD_WAIT - 1);
  localparam logic [3:0] WR_LAST = 4'(WR_CYCLES - 1);

  state_t     r_state;
  logic [1:0] r_mode;
  logic [3:0] r_cnt;
  ctl_t       r_ctl;

  state_t     w_nxt_state;
  logic [1:0] w_nxt_mode;
  logic [3:0] w_nxt_cnt;

  // Moore decode of the strobes for a given (state, mode, counter).
  function automatic ctl_t decode(input state_t s, input logic [1:0] m,
                                  input logic [3:0] c);
    ctl_t o;
    o = '0;
    o.busy = (s != S_IDLE);
    case (s)
      S_T0: begin
        o.grb = 1'b1; o.baout = 1'b1; o.ryi = 1'b1;
      end
      S_T1: begin
        o.csigno = 1'b1; o.alu_add = 1'b1; o.zi = 1'b1;
      end
      S_T2: begin
        o.zlo_out = 1'b1;
        if (m == MODE_LDI) begin
          o.gra = 1'b1; o.rin = 1'b1;
        end else begin
          o.mari = 1'b1;
        end
      end
      S_T3: begin
        if (m == MODE_ST) begin
          o.gra = 1'b1; o.rout = 1'b1; o.mdri = 1'b1;
        end else begin
          // MDR captures the RAM data only in the final read-wait cycle
          o.mem_read = 1'b1;
          o.mdri     = (c == RD_LAST);
        end
      end
      S_T4: begin
        if (m == MODE_ST) begin
          o.mem_write = 1'b1;
        end else begin
          o.mdro = 1'b1; o.gra = 1'b1; o.rin = 1'b1;
        end
      end
      S_DONE: begin
        o.done = 1'b1;
        o.err  = (m == MODE_ILL);
      end
      default: o = '0;
    endcase
    return o;
  endfunction

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_mode  = r_mode;
    w_nxt_cnt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_nxt_mode  = mode;
          w_nxt_cnt   = 4'd0;
          w_nxt_state = (mode == MODE_ILL) ? S_DONE : S_T0;
        end
      end
      S_T0: w_nxt_state = S_T1;
      S_T1: w_nxt_state = S_T2;
      S_T2: begin
        w_nxt_cnt   = 4'd0;
        w_nxt_state = (r_mode == MODE_LDI) ? S_DONE : S_T3;
      end
      S_T3: begin
        if (r_mode == MODE_ST || r_cnt == RD_LAST) begin
          w_nxt_cnt   = 4'd0;
          w_nxt_state = S_T4;
        end else begin
          w_nxt_cnt = r_cnt + 4'd1;
        end
      end
      S_T4: begin
        if (r_mode != MODE_ST || r_cnt == WR_LAST) begin
          w_nxt_cnt   = 4'd0;
          w_nxt_state = S_DONE;
        end else begin
          w_nxt_cnt = r_cnt + 4'd1;
        end
      end
      S_DONE:  w_nxt_state = S_IDLE;
      default: w_nxt_state = S_IDLE;
    endcase
  end

  // Outputs are registered from the decode of the next state so they line up
  // with the state they describe while staying glitch-free.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state <= S_IDLE;
      r_mode  <= MODE_LD;
      r_cnt   <= 4'd0;
      r_ctl   <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_mode  <= w_nxt_mode;
      r_cnt   <= w_nxt_cnt;
      r_ctl   <= decode(w_nxt_state, w_nxt_mode, w_nxt_cnt);
    end
  end

  assign busy      = r_ctl.busy;
  assign done      = r_ctl.done;
  assign err       = r_ctl.err;
  assign grb       = r_ctl.grb;
  assign baout     = r_ctl.baout;
  assign ryi       = r_ctl.ryi;
  assign csigno    = r_ctl.csigno;
  assign alu_add   = r_ctl.alu_add;
  assign zi        = r_ctl.zi;
  assign zlo_out   = r_ctl.zlo_out;
  assign gra       = r_ctl.gra;
  assign rin       = r_ctl.rin;
  assign rout      = r_ctl.rout;
  assign mari      = r_ctl.mari;
  assign mdri      = r_ctl.mdri;
  assign mdro      = r_ctl.mdro;
  assign mem_read  = r_ctl.mem_read;
  assign mem_write = r_ctl.mem_write;

endmodule
